bisr_repair_map: RTL and testbench
==================================

// Module: bisr_repair_map
// PURPOSE
//  Repair side of the memctrl BIST/BISR loop. Collects fail reports ({select,addr}) from the
//  BIST engine into a register-based spare table. After BIST ends it locks the table and
//  redirects functional accesses to faulty words into spare data registers.
//  Sits between the BIST engine / functional memctrl and the 64-bank SRAM array.
// PARAMETERS
//  NUM_SPARE  8   number of spare word entries (CAM + data register)
//  ADDR_W     10  word address width inside one bank
//  SEL_W      6   bank select width (64 banks)
//  DATA_W     8   data width
// PORTS
//  CLK            in   1        clock
//  RSTN           in   1        asynchronous active-low reset
//  BIST_EN        in   1        BIST session active
//  FAIL_VALID     in   1        one-cycle fail report from BIST
//  FAIL_ADDR      in   ADDR_W   failing word address
//  FAIL_SEL       in   SEL_W    failing bank select
//  MEM_CE         in   1        functional access strobe
//  MEM_WEB        in   1        0=write, 1=read
//  MEM_ADDR       in   ADDR_W   functional address
//  MEM_SEL        in   SEL_W    functional bank select
//  MEM_IDATA      in   DATA_W   functional write data
//  REPAIR_WMASK   out  1        comb: current write hits a spare; memctrl suppresses array write
//  REPAIR_HIT     out  1        registered: previous-cycle read hit a spare; mux REPAIR_ODATA
//  REPAIR_ODATA   out  DATA_W   registered spare read data
//  REPAIR_CNT     out  $clog2(NUM_SPARE+1)  allocated entries
//  REPAIR_FULL    out  1        REPAIR_CNT == NUM_SPARE
//  REPAIR_OVF     out  1        sticky: unique fail arrived while full (unrepairable)
//  MAP_LOCKED     out  1        state == LOCKED
// BEHAVIOUR
//  Reset: state IDLE; all valid bits, keys, spare data, REPAIR_CNT, REPAIR_OVF, REPAIR_HIT,
//   REPAIR_ODATA = 0; REPAIR_FULL=0, MAP_LOCKED=0. RSTN mid-session discards the table.
//  FSM (one-hot): IDLE -> CLEAR when BIST_EN=1. CLEAR (1 cycle): clear valid, CNT, OVF,
//   spare data -> CAPTURE. CAPTURE: BIST_EN=0 -> LOCKED. LOCKED: BIST_EN=1 -> CLEAR.
//  FAIL_VALID honoured only in CAPTURE (ignored in IDLE/CLEAR/LOCKED, incl. same cycle as
//   BIST_EN fall: that cycle is still CAPTURE, so it is captured).
//  Capture: key={FAIL_SEL,FAIL_ADDR}; compare vs all valid entries.
//   match -> no change (duplicate); no match & CNT<NUM_SPARE -> entry[CNT] key written,
//   valid=1, data=0, CNT+1 next edge; no match & full -> REPAIR_OVF<=1, table unchanged.
//  Entries allocated in ascending index order; never freed except by CLEAR or reset.
//  Remap active only in LOCKED; in IDLE/CLEAR/CAPTURE REPAIR_WMASK=0 and REPAIR_HIT<=0
//   so BIST sees the raw array.
//  Lookup key={MEM_SEL,MEM_ADDR}; at most one entry matches (guaranteed by dedupe).
//  Write (CE=1,WEB=0,hit): REPAIR_WMASK=1 same cycle; spare data<=MEM_IDATA next edge.
//  Read (CE=1,WEB=1): next edge REPAIR_HIT<=hit, REPAIR_ODATA<=hit?spare data:0
//   (1-cycle latency, matches SRAM read latency). CE=0 -> REPAIR_HIT<=0, ODATA held.
//  Read-after-write same entry, back to back: read returns the newly written data.
//  CNT width holds NUM_SPARE exactly; no wrap. OVF clears only in CLEAR or reset.
// TESTING
//  T1 reset, BIST_EN=1, 3 fails {1,0x010},{2,0x3FF},{63,0x000} -> CNT=3, FULL=0, OVF=0.
//  T2 repeat fail {2,0x3FF} twice more -> CNT stays 3, no new entry.
//  T3 9 unique fails -> CNT=8, FULL=1, OVF=1; entry 0..7 keys = first 8 in order.
//  T4 after T1, BIST_EN=0 -> MAP_LOCKED next cycle; write 0xA5 to {2,0x3FF} -> WMASK=1;
//     read same -> next cycle HIT=1, ODATA=0xA5; read {2,0x3FE} -> HIT=0, WMASK stays 0.
//  T5 from LOCKED, BIST_EN=1 -> CLEAR then CAPTURE: CNT=0, OVF=0, prior key read HIT=0.
//  T6 RSTN low mid-CAPTURE after 2 fails -> all outputs reset values, state IDLE, CNT=0.

Source files
------------

// File: rtl/bisr_repair_map.sv
// ---------------------------------------------------------------------------
// bisr_repair_map
//   Repair side of the memctrl BIST/BISR loop. During a BIST session, fail
//   reports ({select,addr}) are deduplicated into a small register-based spare
//   table. When BIST ends the table is locked, and functional accesses that hit
//   a faulty word are redirected to the matching spare data register.
//
// Ports
//   CLK, RSTN                       clock, asynchronous active-low reset
//   BIST_EN                         BIST session active
//   FAIL_VALID/FAIL_ADDR/FAIL_SEL   one-cycle fail report from the BIST engine
//   MEM_CE/MEM_WEB/MEM_ADDR/MEM_SEL/MEM_IDATA
//                                   functional access (WEB: 0=write, 1=read)
//   REPAIR_WMASK                    comb: current write hits a spare entry
//   REPAIR_HIT/REPAIR_ODATA         registered: previous read hit, spare data
//   REPAIR_CNT/REPAIR_FULL          allocated entries / table full
//   REPAIR_OVF                      sticky: unique fail seen while table full
//   MAP_LOCKED                      table locked, remap active
// ---------------------------------------------------------------------------
module bisr_repair_map #(
    parameter int NUM_SPARE = 8,
    parameter int ADDR_W    = 10,
    parameter int SEL_W     = 6,
    parameter int DATA_W    = 8,
    localparam int CNT_W    = $clog2(NUM_SPARE + 1)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              BIST_EN,
    input  logic              FAIL_VALID,
    input  logic [ADDR_W-1:0] FAIL_ADDR,
    input  logic [SEL_W-1:0]  FAIL_SEL,
    input  logic              MEM_CE,
    input  logic              MEM_WEB,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [SEL_W-1:0]  MEM_SEL,
    input  logic [DATA_W-1:0] MEM_IDATA,
    output logic              REPAIR_WMASK,
    output logic              REPAIR_HIT,
    output logic [DATA_W-1:0] REPAIR_ODATA,
    output logic [CNT_W-1:0]  REPAIR_CNT,
    output logic              REPAIR_FULL,
    output logic              REPAIR_OVF,
    output logic              MAP_LOCKED
);

    localparam int KEY_W = SEL_W + ADDR_W;

    // One-hot state encoding
    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_CLEAR   = 4'b0010;
    localparam logic [3:0] ST_CAPTURE = 4'b0100;
    localparam logic [3:0] ST_LOCKED  = 4'b1000;

    logic [3:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ovf_reg;
    logic              hit_reg;
    logic [DATA_W-1:0] odata_reg;

    logic              valid_reg [NUM_SPARE];
    logic [KEY_W-1:0]  key_reg   [NUM_SPARE];
    logic [DATA_W-1:0] data_reg  [NUM_SPARE];

    logic [NUM_SPARE-1:0] fail_match;
    logic [NUM_SPARE-1:0] mem_match;
    logic [KEY_W-1:0]     fail_key;
    logic [KEY_W-1:0]     mem_key;
    logic [DATA_W-1:0]    rd_data;

    logic in_clear, in_capture, in_locked;
    logic full, fail_dup, capture_new, capture_ovf;
    logic mem_hit, wr_hit;

    assign fail_key   = {FAIL_SEL, FAIL_ADDR};
    assign mem_key    = {MEM_SEL, MEM_ADDR};

    assign in_clear   = (state_reg == ST_CLEAR);
    assign in_capture = (state_reg == ST_CAPTURE);
    assign in_locked  = (state_reg == ST_LOCKED);

    assign full        = (cnt_reg == CNT_W'(NUM_SPARE));
    assign fail_dup    = |fail_match;
    assign capture_new = in_capture && FAIL_VALID && !fail_dup && !full;
    assign capture_ovf = in_capture && FAIL_VALID && !fail_dup && full;

    // Remap is only visible once locked so BIST always sees the raw array.
    assign mem_hit = in_locked && (|mem_match);
    assign wr_hit  = MEM_CE && !MEM_WEB && mem_hit;

    // Per-entry CAM compare and storage. Entry gi is allocated only when the
    // count points at it, which keeps allocation in ascending index order.
    for (genvar gi = 0; gi < NUM_SPARE; gi++) begin : g_entry
        assign fail_match[gi] = valid_reg[gi] && (key_reg[gi] == fail_key);
        assign mem_match[gi]  = valid_reg[gi] && (key_reg[gi] == mem_key);

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                valid_reg[gi] <= 1'b0;
                key_reg[gi]   <= '0;
                data_reg[gi]  <= '0;
            end else if (in_clear) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
            end else if (capture_new && (cnt_reg == CNT_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
                key_reg[gi]   <= fail_key;
                data_reg[gi]  <= '0;
            end else if (wr_hit && mem_match[gi]) begin
                data_reg[gi]  <= MEM_IDATA;
            end
        end
    end

    // Dedupe guarantees at most one match, so an OR-mux is sufficient.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SPARE; i++) begin
            if (mem_match[i]) begin
                rd_data = rd_data | data_reg[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:    if (BIST_EN)  state_next = ST_CLEAR;
            ST_CLEAR:                 state_next = ST_CAPTURE;
            ST_CAPTURE: if (!BIST_EN) state_next = ST_LOCKED;
            ST_LOCKED:  if (BIST_EN)  state_next = ST_CLEAR;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            hit_reg   <= 1'b0;
            odata_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (in_clear) begin
                cnt_reg <= '0;
                ovf_reg <= 1'b0;
            end else begin
                if (capture_new) cnt_reg <= cnt_reg + 1'b1;
                if (capture_ovf) ovf_reg <= 1'b1;
            end

            // Read data follows the SRAM's one-cycle latency; ODATA holds
            // when no read is issued.
            if (in_locked && MEM_CE && MEM_WEB) begin
                hit_reg   <= mem_hit;
                odata_reg <= mem_hit ? rd_data : '0;
            end else begin
                hit_reg   <= 1'b0;
            end
        end
    end

    assign REPAIR_WMASK = wr_hit;
    assign REPAIR_HIT   = hit_reg;
    assign REPAIR_ODATA = odata_reg;
    assign REPAIR_CNT   = cnt_reg;
    assign REPAIR_FULL  = full;
    assign REPAIR_OVF   = ovf_reg;
    assign MAP_LOCKED   = in_locked;

endmodule

// File: tb/tb_bisr_repair_map.sv
// ---------------------------------------------------------------------------
// tb_bisr_repair_map
//   Directed bench for bisr_repair_map. Each vector drives one clock cycle of
//   inputs; REPAIR_WMASK is sampled within that cycle, the registered outputs
//   after the following rising edge. Multi-cycle corner cases (full table,
//   overflow, mid-session reset) are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_bisr_repair_map;

    typedef struct packed {
        logic       bist;
        logic       fv;
        logic [5:0] fsel;
        logic [9:0] faddr;
        logic       ce;
        logic       web;
        logic [5:0] msel;
        logic [9:0] maddr;
        logic [7:0] idata;
        logic       e_wmask;
        logic [3:0] e_cnt;
        logic       e_full;
        logic       e_ovf;
        logic       e_lock;
        logic       e_hit;
        logic [7:0] e_odata;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       BIST_EN = 1'b0;
    logic       FAIL_VALID = 1'b0;
    logic [9:0] FAIL_ADDR = '0;
    logic [5:0] FAIL_SEL = '0;
    logic       MEM_CE = 1'b0;
    logic       MEM_WEB = 1'b1;
    logic [9:0] MEM_ADDR = '0;
    logic [5:0] MEM_SEL = '0;
    logic [7:0] MEM_IDATA = '0;
    logic       REPAIR_WMASK;
    logic       REPAIR_HIT;
    logic [7:0] REPAIR_ODATA;
    logic [3:0] REPAIR_CNT;
    logic       REPAIR_FULL;
    logic       REPAIR_OVF;
    logic       MAP_LOCKED;

    int checks = 0;
    int failures = 0;

    bisr_repair_map dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .BIST_EN      (BIST_EN),
        .FAIL_VALID   (FAIL_VALID),
        .FAIL_ADDR    (FAIL_ADDR),
        .FAIL_SEL     (FAIL_SEL),
        .MEM_CE       (MEM_CE),
        .MEM_WEB      (MEM_WEB),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_SEL      (MEM_SEL),
        .MEM_IDATA    (MEM_IDATA),
        .REPAIR_WMASK (REPAIR_WMASK),
        .REPAIR_HIT   (REPAIR_HIT),
        .REPAIR_ODATA (REPAIR_ODATA),
        .REPAIR_CNT   (REPAIR_CNT),
        .REPAIR_FULL  (REPAIR_FULL),
        .REPAIR_OVF   (REPAIR_OVF),
        .MAP_LOCKED   (MAP_LOCKED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic bist, input logic fv, input logic [5:0] fs,
                                input logic [9:0] fa, input logic ce, input logic web,
                                input logic [5:0] ms, input logic [9:0] ma,
                                input logic [7:0] d, input logic ew, input logic [3:0] ec,
                                input logic ef, input logic eo, input logic el,
                                input logic eh, input logic [7:0] eod);
        vec_t v;
        v.bist = bist; v.fv = fv; v.fsel = fs; v.faddr = fa;
        v.ce = ce; v.web = web; v.msel = ms; v.maddr = ma; v.idata = d;
        v.e_wmask = ew; v.e_cnt = ec; v.e_full = ef; v.e_ovf = eo;
        v.e_lock = el; v.e_hit = eh; v.e_odata = eod;
        return v;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        BIST_EN    = v.bist;
        FAIL_VALID = v.fv;
        FAIL_SEL   = v.fsel;
        FAIL_ADDR  = v.faddr;
        MEM_CE     = v.ce;
        MEM_WEB    = v.web;
        MEM_SEL    = v.msel;
        MEM_ADDR   = v.maddr;
        MEM_IDATA  = v.idata;
        #2;
        chk({tag, ".wmask"}, 32'(REPAIR_WMASK), 32'(v.e_wmask));
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ".cnt"},   32'(REPAIR_CNT),   32'(v.e_cnt));
        chk({tag, ".full"},  32'(REPAIR_FULL),  32'(v.e_full));
        chk({tag, ".ovf"},   32'(REPAIR_OVF),   32'(v.e_ovf));
        chk({tag, ".lock"},  32'(MAP_LOCKED),   32'(v.e_lock));
        chk({tag, ".hit"},   32'(REPAIR_HIT),   32'(v.e_hit));
        chk({tag, ".odata"}, 32'(REPAIR_ODATA), 32'(v.e_odata));
        $display("vec %s cnt=%0d full=%0b ovf=%0b lock=%0b wmask=%0b hit=%0b odata=%02h",
                 tag, REPAIR_CNT, REPAIR_FULL, REPAIR_OVF, MAP_LOCKED, v.e_wmask,
                 REPAIR_HIT, REPAIR_ODATA);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cnt"},   32'(REPAIR_CNT),   0);
        chk({tag, ".full"},  32'(REPAIR_FULL),  0);
        chk({tag, ".ovf"},   32'(REPAIR_OVF),   0);
        chk({tag, ".lock"},  32'(MAP_LOCKED),   0);
        chk({tag, ".hit"},   32'(REPAIR_HIT),   0);
        chk({tag, ".odata"}, 32'(REPAIR_ODATA), 0);
        chk({tag, ".wmask"}, 32'(REPAIR_WMASK), 0);
    endtask

    vec_t tbl[$];

    initial begin
        //            bist fv fsel  faddr   ce web msel  maddr   data  wm cnt f o l h odata
        // IDLE / CLEAR: fail reports ignored
        tbl.push_back(mk(1, 1, 6'd4,  10'h004, 0, 1, 6'd0,  10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 6'd4,  10'h004, 0, 1, 6'd0,  10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
        // T1: three unique fails
        tbl.push_back(mk(1, 1, 6'd1,  10'h010, 0, 1, 6'd0,  10'h000, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 6'd2,  10'h3FF, 0, 1, 6'd0,  10'h000, 8'h00, 0, 2, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 6'd63, 10'h000, 0, 1, 6'd0,  10'h000, 8'h00, 0, 3, 0, 0, 0, 0, 8'h00));
        // T2: duplicates
        tbl.push_back(mk(1, 1, 6'd2,  10'h3FF, 0, 1, 6'd0,  10'h000, 8'h00, 0, 3, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 6'd2,  10'h3FF, 0, 1, 6'd0,  10'h000, 8'h00, 0, 3, 0, 0, 0, 0, 8'h00));
        // T4: lock and remap
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 0, 1, 6'd0,  10'h000, 8'h00, 0, 3, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 0, 6'd2,  10'h3FF, 8'hA5, 1, 3, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 1, 6'd2,  10'h3FF, 8'h00, 0, 3, 0, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 1, 6'd2,  10'h3FE, 8'h00, 0, 3, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 0, 6'd1,  10'h010, 8'h3C, 1, 3, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 1, 6'd1,  10'h010, 8'h00, 0, 3, 0, 0, 1, 1, 8'h3C));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 0, 1, 6'd1,  10'h010, 8'h00, 0, 3, 0, 0, 1, 0, 8'h3C));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 0, 6'd63, 10'h000, 8'h77, 1, 3, 0, 0, 1, 0, 8'h3C));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 1, 6'd63, 10'h000, 8'h00, 0, 3, 0, 0, 1, 1, 8'h77));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 1, 6'd1,  10'h010, 8'h00, 0, 3, 0, 0, 1, 1, 8'h3C));
        tbl.push_back(mk(0, 0, 6'd0,  10'h000, 1, 0, 6'd5,  10'h005, 8'h11, 0, 3, 0, 0, 1, 0, 8'h3C));
        tbl.push_back(mk(0, 1, 6'd7,  10'h007, 0, 1, 6'd0,  10'h000, 8'h00, 0, 3, 0, 0, 1, 0, 8'h3C));
        // T5: new session clears the table
        tbl.push_back(mk(1, 0, 6'd0,  10'h000, 0, 1, 6'd0,  10'h000, 8'h00, 0, 3, 0, 0, 0, 0, 8'h3C));
        tbl.push_back(mk(1, 0, 6'd0,  10'h000, 1, 1, 6'd2,  10'h3FF, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3C));
        tbl.push_back(mk(1, 0, 6'd0,  10'h000, 1, 0, 6'd2,  10'h3FF, 8'h99, 0, 0, 0, 0, 0, 0, 8'h3C));
        tbl.push_back(mk(1, 0, 6'd0,  10'h000, 1, 1, 6'd2,  10'h3FF, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3C));

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("reset");
        $display("reset check cnt=%0d lock=%0b", REPAIR_CNT, MAP_LOCKED);
        RSTN = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("t%0d", i));
        end

        // T3: fill table, duplicate while full, then overflow (state CAPTURE, cnt 0)
        for (int k = 0; k < 8; k++) begin
            apply(mk(1, 1, 6'(10 + k), 10'(7 * k + 1), 0, 1, 6'd0, 10'h000, 8'h00,
                     0, 4'(k + 1), (k == 7), 0, 0, 0, 8'h3C), $sformatf("fill%0d", k));
        end
        apply(mk(1, 1, 6'd10, 10'd1, 0, 1, 6'd0, 10'h000, 8'h00, 0, 8, 1, 0, 0, 0, 8'h3C), "dupfull");
        apply(mk(1, 1, 6'd18, 10'd57, 0, 1, 6'd0, 10'h000, 8'h00, 0, 8, 1, 1, 0, 0, 8'h3C), "ovf");
        apply(mk(0, 0, 6'd0, 10'h000, 0, 1, 6'd0, 10'h000, 8'h00, 0, 8, 1, 1, 1, 0, 8'h3C), "lock8");
        for (int k = 0; k < 8; k++) begin
            apply(mk(0, 0, 6'd0, 10'h000, 1, 0, 6'(10 + k), 10'(7 * k + 1), 8'(8'h40 + k),
                     1, 8, 1, 1, 1, 0, (k == 0) ? 8'h3C : 8'(8'h40 + k - 1)),
                  $sformatf("wr%0d", k));
            apply(mk(0, 0, 6'd0, 10'h000, 1, 1, 6'(10 + k), 10'(7 * k + 1), 8'h00,
                     0, 8, 1, 1, 1, 1, 8'(8'h40 + k)), $sformatf("rd%0d", k));
        end
        apply(mk(0, 0, 6'd0, 10'h000, 1, 0, 6'd18, 10'd57, 8'hEE, 0, 8, 1, 1, 1, 0, 8'h47), "wr8");
        apply(mk(0, 0, 6'd0, 10'h000, 1, 1, 6'd18, 10'd57, 8'h00, 0, 8, 1, 1, 1, 0, 8'h00), "rd8");

        // Capture on the cycle BIST_EN falls; fails during LOCKED/CLEAR ignored
        apply(mk(1, 1, 6'd9, 10'd9, 0, 1, 6'd0, 10'h000, 8'h00, 0, 8, 1, 1, 0, 0, 8'h00), "s3lock");
        apply(mk(1, 1, 6'd9, 10'd9, 0, 1, 6'd0, 10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "s3clr");
        apply(mk(1, 0, 6'd0, 10'd0, 0, 1, 6'd0, 10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "s3cap");
        apply(mk(0, 1, 6'd3, 10'd3, 0, 1, 6'd0, 10'h000, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00), "s3fall");
        apply(mk(0, 0, 6'd0, 10'd0, 1, 1, 6'd3, 10'd3,   8'h00, 0, 1, 0, 0, 1, 1, 8'h00), "s3rd");
        apply(mk(0, 0, 6'd0, 10'd0, 1, 1, 6'd9, 10'd9,   8'h00, 0, 1, 0, 0, 1, 0, 8'h00), "s3miss");

        // T6: reset mid-CAPTURE after two fails
        apply(mk(1, 0, 6'd0, 10'd0, 0, 1, 6'd0, 10'h000, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00), "s4lock");
        apply(mk(1, 0, 6'd0, 10'd0, 0, 1, 6'd0, 10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "s4clr");
        apply(mk(1, 1, 6'd1, 10'd1, 0, 1, 6'd0, 10'h000, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00), "s4f1");
        apply(mk(1, 1, 6'd2, 10'd2, 0, 1, 6'd0, 10'h000, 8'h00, 0, 2, 0, 0, 0, 0, 8'h00), "s4f2");
        FAIL_VALID = 1'b0;
        RSTN = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        $display("mid-session reset cnt=%0d lock=%0b", REPAIR_CNT, MAP_LOCKED);
        @(negedge CLK);
        RSTN = 1'b1;
        // IDLE ignores fails and does not lock on BIST_EN=0
        apply(mk(0, 1, 6'd5, 10'd5, 0, 1, 6'd0, 10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "idle");
        apply(mk(1, 0, 6'd0, 10'd0, 0, 1, 6'd0, 10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "idle2clr");
        apply(mk(1, 1, 6'd6, 10'd6, 0, 1, 6'd0, 10'h000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "clr");
        apply(mk(1, 1, 6'd6, 10'd6, 0, 1, 6'd0, 10'h000, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00), "cap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
